// File: rtl/field_scanner.sv
// Metaball field scanner: rasters every pixel, collects per-ball contributions over the
// px_stb/vld handshake, thresholds the saturated field sum and writes the framebuffer.
module field_scanner #(
  parameter int          N_BALLS = 3,
  parameter int          COLS    = 32,
  parameter int          ROWS    = 64,
  parameter logic [31:0] THRESH  = 32'h0000_8000,
  parameter int          TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick_i,
  output logic                         px_stb_o,
  output logic [31:0]                  p_x_o,
  output logic [31:0]                  p_y_o,
  input  logic [N_BALLS-1:0]           vld_i,
  input  logic [N_BALLS*32-1:0]        contrib_i,
  output logic                         wr_en_o,
  output logic [$clog2(COLS*ROWS)-1:0] wr_addr_o,
  output logic                         wr_lit_o,
  output logic [31:0]                  wr_field_o,
  output logic                         mov_en_o,
  output logic                         frame_done_o,
  output logic                         busy_o,
  output logic                         overrun_o,
  output logic                         err_o
);

  localparam int ADDR_W = $clog2(COLS * ROWS);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SUM_W  = 32 + $clog2(N_BALLS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_GUARD, S_WAIT, S_ACCUM, S_WRITE, S_MOVE
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic [N_BALLS-1:0] mask_q, mask_d;
  logic [31:0]        field_q, field_d;
  logic               lit_q, lit_d;
  logic               err_q, err_d;
  logic               busy_q, px_stb_q, wr_en_q, mov_q, done_q, overrun_q;

  logic [SUM_W-1:0]   sum_raw;
  logic [31:0]        sum_sat;

  // Negative contributions and balls masked out by a timeout add nothing.
  always_comb begin
    sum_raw = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (mask_q[i] && !contrib_i[32*i+31])
        sum_raw = sum_raw + SUM_W'(contrib_i[32*i +: 32]);
    end
    sum_sat = (sum_raw > SUM_W'(32'h7FFF_FFFF)) ? 32'h7FFF_FFFF : sum_raw[31:0];
  end

  // NOTE: every variable gets its default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    mask_d  = mask_q;
    field_d = field_q;
    lit_d   = lit_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick_i) begin
          state_d = S_STROBE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      S_STROBE: state_d = S_GUARD;
      S_GUARD: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (&vld_i) begin
          state_d = S_ACCUM;
          mask_d  = '1;
        end else if (wcnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_ACCUM;
          mask_d  = vld_i;
          err_d   = 1'b1;
        end
      end
      S_ACCUM: begin
        state_d = S_WRITE;
        field_d = sum_sat;
        lit_d   = (sum_sat >= THRESH);
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (col_q == COL_W'(COLS - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(ROWS - 1)) begin
            row_d   = '0;
            state_d = S_MOVE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_STROBE;
          end
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_STROBE;
        end
      end
      S_MOVE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      mask_q    <= '0;
      field_q   <= '0;
      lit_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      px_stb_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      mov_q     <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      mask_q    <= mask_d;
      field_q   <= field_d;
      lit_q     <= lit_d;
      err_q     <= err_d;
      busy_q    <= (state_d != S_IDLE);
      px_stb_q  <= (state_d == S_STROBE);
      wr_en_q   <= (state_d == S_WRITE);
      mov_q     <= (state_d == S_MOVE);
      done_q    <= (state_d == S_MOVE);
      overrun_q <= frame_tick_i && (state_q != S_IDLE);
    end
  end

  assign px_stb_o     = px_stb_q;
  assign p_x_o        = 32'(col_q) << 15;
  assign p_y_o        = 32'(row_q) << 15;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = addr_q;
  assign wr_lit_o     = lit_q;
  assign wr_field_o   = field_q;
  assign mov_en_o     = mov_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_field_scanner.sv
// Self-checking bench for field_scanner: randomized ball responders driven from a per-pixel
// plan, with expected writes computed from the plan by plain arithmetic.
module tb_field_scanner;

  localparam int          COLS    = 32;
  localparam int          ROWS    = 64;
  localparam int          NPIX    = COLS * ROWS;
  localparam int          TIMEOUT = 64;
  localparam int          NB      = 3;
  localparam logic [31:0] THRESH  = 32'h0000_8000;
  localparam int          NEVER   = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick3 = 1'b0;
  logic tick1 = 1'b0;

  logic           px_stb3, wr_en3, wr_lit3, mov_en3, frame_done3, busy3, overrun3, err3;
  logic [31:0]    p_x3, p_y3, wr_field3;
  logic [10:0]    wr_addr3;
  logic [NB-1:0]  vld3;
  logic [NB*32-1:0] contrib3;

  logic           px_stb1, wr_en1, wr_lit1, mov_en1, frame_done1, busy1, overrun1, err1;
  logic [31:0]    p_x1, p_y1, wr_field1;
  logic [10:0]    wr_addr1;
  logic [0:0]     vld1;
  logic [31:0]    contrib1;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          err_exp = 1'b0;
  int          rise [NPIX][NB];
  logic [31:0] val  [NPIX][NB];

  always #5 clk = ~clk;

  field_scanner #(.N_BALLS(NB), .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH), .TIMEOUT(TIMEOUT)) u_dut3 (
    .clk(clk), .rst(rst), .frame_tick_i(tick3), .px_stb_o(px_stb3), .p_x_o(p_x3), .p_y_o(p_y3),
    .vld_i(vld3), .contrib_i(contrib3), .wr_en_o(wr_en3), .wr_addr_o(wr_addr3), .wr_lit_o(wr_lit3),
    .wr_field_o(wr_field3), .mov_en_o(mov_en3), .frame_done_o(frame_done3), .busy_o(busy3),
    .overrun_o(overrun3), .err_o(err3)
  );

  field_scanner #(.N_BALLS(1), .COLS(COLS), .ROWS(ROWS), .THRESH(THRESH), .TIMEOUT(TIMEOUT)) u_dut1 (
    .clk(clk), .rst(rst), .frame_tick_i(tick1), .px_stb_o(px_stb1), .p_x_o(p_x1), .p_y_o(p_y1),
    .vld_i(vld1), .contrib_i(contrib1), .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_lit_o(wr_lit1),
    .wr_field_o(wr_field1), .mov_en_o(mov_en1), .frame_done_o(frame_done1), .busy_o(busy1),
    .overrun_o(overrun1), .err_o(err1)
  );

  // Ball responders: counted in cycles after px_stb. vld stays high (stale) through the
  // cycle after px_stb with junk contrib, then follows the plan for the pixel.
  int k3 = NEVER - 1;
  int strobe_n3 = 0;
  int pix3 = 0;
  always @(negedge clk) begin
    if (rst) begin
      vld3 = '0; contrib3 = '0; k3 = NEVER - 1; strobe_n3 = 0; pix3 = 0;
    end else if (px_stb3) begin
      pix3 = strobe_n3 % NPIX;
      strobe_n3++;
      k3 = 0;
    end else begin
      if (k3 < NEVER - 1) k3++;
      for (int i = 0; i < NB; i++) begin
        if (k3 == 1) begin
          contrib3[32*i +: 32] = $urandom;
        end else if (k3 >= 2) begin
          if (rise[pix3][i] <= k3) begin
            vld3[i] = 1'b1;
            contrib3[32*i +: 32] = val[pix3][i];
          end else begin
            vld3[i] = 1'b0;
            contrib3[32*i +: 32] = $urandom;
          end
        end
      end
    end
  end

  int k1 = NEVER - 1;
  always @(negedge clk) begin
    if (rst) begin
      vld1 = '0; contrib1 = '0; k1 = NEVER - 1;
    end else if (px_stb1) begin
      k1 = 0;
    end else begin
      if (k1 < NEVER - 1) k1++;
      vld1     = (k1 >= 5) ? 1'b1 : 1'b0;
      contrib1 = (k1 >= 5) ? 32'h0000_8000 : 32'h0000_0000;
    end
  end

  task automatic fill_random();
    int r;
    for (int p = 0; p < NPIX; p++) begin
      for (int i = 0; i < NB; i++) begin
        rise[p][i] = $urandom_range(5, 2);
        r = $urandom_range(7, 0);
        if (r == 0)      val[p][i] = 32'h8000_0000 | $urandom;
        else if (r == 1) val[p][i] = 32'h6000_0000 + $urandom_range(255, 0);
        else             val[p][i] = $urandom_range(32'h6000, 0);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    err_exp = 1'b0;
  endtask

  // Runs one full frame on the 3-ball instance and checks every strobe and write.
  task automatic scan_frame(input string tag, input int ovr_at, input bit tick_in_move);
    int s, w, n_mov, n_ovr, t, t_stb, m, exp_lat;
    bit done, ovr_due, to, exp_lit;
    logic [31:0] exp_x, exp_y, exp_field;
    logic [10:0] exp_addr;
    longint sum;
    s = 0; w = 0; n_mov = 0; n_ovr = 0; t = 0; t_stb = 0;
    done = 1'b0; ovr_due = 1'b0;
    @(negedge clk);
    tick3 = 1'b1;
    @(negedge clk);
    tick3 = 1'b0;
    while (!done && t < 60000) begin
      n_ovr += int'(overrun3);
      if (ovr_due) begin
        tick3 = 1'b0;
        ovr_due = 1'b0;
        n_cmp++;
        if (overrun3 !== 1'b1) begin
          n_bad++;
          $display("FAIL %s overrun_pulse: got %b want 1", tag, overrun3);
        end
      end
      if (px_stb3) begin
        exp_x = (s % COLS) * 32768;
        exp_y = (s / COLS) * 32768;
        n_cmp++;
        if (p_x3 !== exp_x || p_y3 !== exp_y) begin
          n_bad++;
          $display("FAIL %s coord pixel %0d: got x=%h y=%h want x=%h y=%h", tag, s, p_x3, p_y3, exp_x, exp_y);
        end
        t_stb = t;
        s++;
      end
      if (wr_en3) begin
        m = 0;
        for (int i = 0; i < NB; i++) if (rise[w % NPIX][i] > m) m = rise[w % NPIX][i];
        to = (m > TIMEOUT + 1);
        sum = 0;
        for (int i = 0; i < NB; i++)
          if (rise[w % NPIX][i] <= TIMEOUT + 1 && !val[w % NPIX][i][31]) sum += val[w % NPIX][i];
        if (sum > 64'h7FFF_FFFF) sum = 64'h7FFF_FFFF;
        exp_field = sum[31:0];
        exp_lit   = (exp_field >= THRESH);
        exp_lat   = to ? TIMEOUT + 3 : m + 2;
        if (to) err_exp = 1'b1;
        exp_addr  = w[10:0];
        n_cmp++;
        if (wr_addr3 !== exp_addr || wr_field3 !== exp_field || wr_lit3 !== exp_lit ||
            (t - t_stb) != exp_lat || err3 !== err_exp || busy3 !== 1'b1) begin
          n_bad++;
          $display("FAIL %s write %0d: got addr=%0d field=%h lit=%b lat=%0d err=%b busy=%b want addr=%0d field=%h lit=%b lat=%0d err=%b busy=1",
                   tag, w, wr_addr3, wr_field3, wr_lit3, t - t_stb, err3, busy3, exp_addr, exp_field, exp_lit, exp_lat, err_exp);
        end
        if (w == ovr_at) begin
          tick3 = 1'b1;
          ovr_due = 1'b1;
        end
        w++;
      end
      if (mov_en3) begin
        n_mov++;
        n_cmp++;
        if (frame_done3 !== 1'b1 || w != NPIX) begin
          n_bad++;
          $display("FAIL %s mov_en: got frame_done=%b writes=%0d want frame_done=1 writes=%0d", tag, frame_done3, w, NPIX);
        end
      end
      if (frame_done3) done = 1'b1;
      if (!done) begin
        @(negedge clk);
        t++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s frame_timeout: got writes=%0d want frame_done within budget", tag, w);
    end
    n_cmp++;
    if (n_mov != 1 || w != NPIX || n_ovr != ((ovr_at >= 0) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s frame_counts: got mov=%0d writes=%0d overruns=%0d want mov=1 writes=%0d overruns=%0d",
               tag, n_mov, w, n_ovr, NPIX, (ovr_at >= 0) ? 1 : 0);
    end
    if (tick_in_move) begin
      tick3 = 1'b1;
      @(negedge clk);
      tick3 = 1'b0;
      n_cmp++;
      if (overrun3 !== 1'b1 || busy3 !== 1'b0 || px_stb3 !== 1'b0) begin
        n_bad++;
        $display("FAIL %s tick_in_move: got overrun=%b busy=%b px_stb=%b want 1 0 0", tag, overrun3, busy3, px_stb3);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy3 !== 1'b0 || px_stb3 !== 1'b0 || overrun3 !== 1'b0) begin
        n_bad++;
        $display("FAIL %s idle_after_move_tick: got busy=%b px_stb=%b overrun=%b want 0 0 0", tag, busy3, px_stb3, overrun3);
      end
    end else begin
      @(negedge clk);
      n_cmp++;
      if (busy3 !== 1'b0 || mov_en3 !== 1'b0 || frame_done3 !== 1'b0) begin
        n_bad++;
        $display("FAIL %s after_move: got busy=%b mov_en=%b frame_done=%b want 0 0 0", tag, busy3, mov_en3, frame_done3);
      end
    end
  endtask

  task automatic test_reset();
    bit hit;
    int n_ev;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({px_stb3, p_x3, p_y3, wr_en3, wr_addr3, wr_lit3, wr_field3, mov_en3, frame_done3, busy3, overrun3, err3} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b err=%b addr=%0d field=%h want all zero", busy3, err3, wr_addr3, wr_field3);
    end
    fill_random();
    tick3 = 1'b1;
    @(negedge clk);
    tick3 = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 5000 && !hit; t++) begin
      @(negedge clk);
      if (wr_en3 && wr_addr3 == 11'd100) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reach_pixel_100: got no write at addr 100 want one within 5000 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({px_stb3, p_x3, p_y3, wr_en3, wr_addr3, wr_lit3, wr_field3, mov_en3, frame_done3, busy3, overrun3, err3} !== '0) begin
      n_bad++;
      $display("FAIL midscan_reset: got busy=%b wr_en=%b addr=%0d field=%h px=%h want all zero", busy3, wr_en3, wr_addr3, wr_field3, p_x3);
    end
    @(negedge clk);
    rst = 1'b0;
    n_ev = 0;
    repeat (100) begin
      @(negedge clk);
      n_ev += int'(mov_en3) + int'(frame_done3) + int'(px_stb3) + int'(wr_en3) + int'(busy3);
    end
    n_cmp++;
    if (n_ev != 0) begin
      n_bad++;
      $display("FAIL quiet_after_reset: got %0d activity cycles want 0", n_ev);
    end
    tick3 = 1'b1;
    @(negedge clk);
    tick3 = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (wr_en3) hit = 1'b1;
    end
    n_cmp++;
    if (!hit || wr_addr3 !== 11'd0) begin
      n_bad++;
      $display("FAIL restart_addr: got hit=%b addr=%0d want hit=1 addr=0", hit, wr_addr3);
    end
    pulse_reset();
  endtask

  task automatic test_random_frame();
    fill_random();
    scan_frame("random", -1, 1'b0);
  endtask

  task automatic test_directed();
    fill_random();
    rise[10] = '{3, 3, 3};
    val[10]  = '{32'h7000_0000, 32'h7000_0000, 32'h8000_1000};
    rise[11] = '{2, 4, 3};
    val[11]  = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
    rise[19] = '{2, 2, 2};
    rise[20] = '{11, 11, 11};
    rise[30] = '{3, 4, NEVER};
    val[30]  = '{32'h0000_1000, 32'h0000_2000, 32'h0000_4000};
    scan_frame("directed", 40, 1'b1);
  endtask

  task automatic test_single_ball();
    int w, n_mov, t, t_stb;
    bit done;
    logic [10:0] exp_addr;
    n_cmp++;
    if (err3 !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b want 1", err3);
    end
    pulse_reset();
    n_cmp++;
    if (err3 !== 1'b0 || err1 !== 1'b0) begin
      n_bad++;
      $display("FAIL err_cleared: got %b/%b want 0/0", err3, err1);
    end
    w = 0; n_mov = 0; t = 0; t_stb = 0; done = 1'b0;
    tick1 = 1'b1;
    @(negedge clk);
    tick1 = 1'b0;
    while (!done && t < 40000) begin
      if (px_stb1) t_stb = t;
      if (wr_en1) begin
        exp_addr = w[10:0];
        n_cmp++;
        if (wr_addr1 !== exp_addr || wr_lit1 !== 1'b1 || wr_field1 !== 32'h0000_8000 || (t - t_stb) != 7) begin
          n_bad++;
          $display("FAIL single write %0d: got addr=%0d lit=%b field=%h lat=%0d want addr=%0d lit=1 field=00008000 lat=7",
                   w, wr_addr1, wr_lit1, wr_field1, t - t_stb, exp_addr);
        end
        w++;
      end
      if (mov_en1) begin
        n_mov++;
        n_cmp++;
        if (frame_done1 !== 1'b1) begin
          n_bad++;
          $display("FAIL single mov_en: got frame_done=%b want 1", frame_done1);
        end
      end
      if (frame_done1) done = 1'b1;
      @(negedge clk);
      t++;
    end
    repeat (5) begin
      n_mov += int'(mov_en1);
      @(negedge clk);
    end
    n_cmp++;
    if (!done || w != NPIX || n_mov != 1) begin
      n_bad++;
      $display("FAIL single frame_counts: got done=%b writes=%0d mov=%0d want done=1 writes=%0d mov=1", done, w, n_mov, NPIX);
    end
  endtask

  initial begin
    test_reset();
    test_random_frame();
    test_directed();
    test_single_ball();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
